// File: rtl/bsg_adder_cs_pkg.sv
// Shared sizing helpers for the carry-select adder and its blocks.
package bsg_adder_cs_pkg;

  localparam int bsg_adder_cs_block_default_lp = 8;

  function automatic int num_blocks(input int width, input int block);
    return (width + block - 1) / block;
  endfunction

  // Width of the final block; narrower than block when width is not a multiple of it.
  function automatic int last_block_width(input int width, input int block);
    return width - (num_blocks(width, block) - 1) * block;
  endfunction

endpackage

// File: rtl/bsg_adder_cs_block.sv
// One carry-select block: adds with carry-in 0 and 1 in parallel, then muxes on the real carry.
module bsg_adder_cs_block #(
  parameter int width_p = 8
) (
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  input  logic               sel_c_i,
  output logic [width_p-1:0] s_o,
  output logic               c_o
);

  localparam logic [width_p:0] one_lp = (width_p+1)'(1);

  logic [width_p:0] sum0;
  logic [width_p:0] sum1;

  assign sum0 = {1'b0, a_i} + {1'b0, b_i};
  assign sum1 = {1'b0, a_i} + {1'b0, b_i} + one_lp;

  assign {c_o, s_o} = sel_c_i ? sum1 : sum0;

endmodule

// File: rtl/bsg_adder_carry_select_reg.sv
// Registered unsigned carry-select adder: o = a_i + b_i + c_i at width_p+1 bits.
// Define BSG_ADDER_CS_INPUT_REG_EN to add an input register stage (latency 2 instead of 1).
module bsg_adder_carry_select_reg
  import bsg_adder_cs_pkg::*;
#(
  parameter int width_p = 65,
  parameter int block_p = bsg_adder_cs_block_default_lp
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  input  logic               c_i,
  output logic [width_p:0]   o,
  output logic               v_o
);

  localparam int num_blocks_lp = num_blocks(width_p, block_p);
  localparam int last_width_lp = last_block_width(width_p, block_p);

  logic [width_p-1:0] core_a;
  logic [width_p-1:0] core_b;
  logic               core_c;
  logic               core_v;

`ifdef BSG_ADDER_CS_INPUT_REG_EN
  // Operands only load when valid, so junk on idle cycles never reaches the core.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      core_a <= '0;
      core_b <= '0;
      core_c <= 1'b0;
      core_v <= 1'b0;
    end else begin
      core_v <= v_i;
      if (v_i) begin
        core_a <= a_i;
        core_b <= b_i;
        core_c <= c_i;
      end
    end
  end
`else
  assign core_a = a_i;
  assign core_b = b_i;
  assign core_c = c_i;
  assign core_v = v_i;
`endif

  logic [num_blocks_lp:0] carry;
  logic [width_p-1:0]     sum;

  assign carry[0] = core_c;

  for (genvar k = 0; k < num_blocks_lp; k++) begin : g_blk
    localparam int w_lp = (k == num_blocks_lp - 1) ? last_width_lp : block_p;

    bsg_adder_cs_block #(.width_p(w_lp)) blk (
      .a_i    (core_a[k*block_p +: w_lp]),
      .b_i    (core_b[k*block_p +: w_lp]),
      .sel_c_i(carry[k]),
      .s_o    (sum[k*block_p +: w_lp]),
      .c_o    (carry[k+1])
    );
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      o   <= '0;
      v_o <= 1'b0;
    end else begin
      v_o <= core_v;
      if (core_v) o <= {carry[num_blocks_lp], sum};
    end
  end

endmodule

// File: tb/tb_bsg_adder_carry_select_reg.sv
// Directed and swept checks of the registered carry-select adder at 65/8 and 13/4.
module tb_bsg_adder_carry_select_reg;

`ifdef BSG_ADDER_CS_INPUT_REG_EN
  localparam int lat_lp = 2;
`else
  localparam int lat_lp = 1;
`endif

  localparam int sweep_lp = 20000;

  typedef struct {
    logic [64:0] a;
    logic [64:0] b;
    logic        c;
    logic [65:0] exp;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        reset_n_i;

  logic        v_i;
  logic [64:0] a_i, b_i;
  logic        c_i;
  logic [65:0] o;
  logic        v_o;

  logic        v13;
  logic [12:0] a13, b13;
  logic        c13;
  logic [13:0] o13;
  logic        vo13;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  bsg_adder_carry_select_reg #(.width_p(65), .block_p(8)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i),
    .a_i(a_i), .b_i(b_i), .c_i(c_i), .o(o), .v_o(v_o)
  );

  bsg_adder_carry_select_reg #(.width_p(13), .block_p(4)) dut13 (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v13),
    .a_i(a13), .b_i(b13), .c_i(c13), .o(o13), .v_o(vo13)
  );

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic [64:0] a_t, input logic [64:0] b_t, input logic c_t);
    @(negedge clk_i);
    a_i = a_t; b_i = b_t; c_i = c_t; v_i = 1'b1;
    repeat (lat_lp) @(posedge clk_i);
    #1;
  endtask

  vec_t vecs [10];

  initial begin
    logic [13:0] exp13;
    logic [13:0] q_exp [$];
    logic [13:0] want;
    int          sweep_fail;

    vecs[0] = '{65'h1_FFFF_FFFF_FFFF_FFFF, 65'h0, 1'b1, 66'h2_0000_0000_0000_0000};
    vecs[1] = '{65'h1_FFFF_FFFF_FFFF_FFFF, 65'h1_FFFF_FFFF_FFFF_FFFF, 1'b1, 66'h3_FFFF_FFFF_FFFF_FFFF};
    vecs[2] = '{65'h0, 65'h0, 1'b0, 66'h0};
    vecs[3] = '{65'hFF, 65'h01, 1'b0, 66'h100};
    vecs[4] = '{65'h7F, 65'h80, 1'b1, 66'h100};
    vecs[5] = '{65'h1_FFFF_FFFF_FFFF_FFFF, 65'h0, 1'b0, 66'h1_FFFF_FFFF_FFFF_FFFF};
    vecs[6] = '{65'h1_0000_0000_0000_0000, 65'h1_0000_0000_0000_0000, 1'b0, 66'h2_0000_0000_0000_0000};
    vecs[7] = '{65'h0_FFFF_FFFF_FFFF_FFFF, 65'h1, 1'b0, 66'h1_0000_0000_0000_0000};
    vecs[8] = '{65'h1234_5678, 65'h1111_1111, 1'b0, 66'h2345_6789};
    vecs[9] = '{65'h0_FFFF_FFFF, 65'h0, 1'b1, 66'h1_0000_0000};

    reset_n_i = 1'b0;
    v_i = 1'b0; a_i = '0; b_i = '0; c_i = 1'b0;
    v13 = 1'b0; a13 = '0; b13 = '0; c13 = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_o", o, 66'h0);
    check("reset_v_o", {65'h0, v_o}, 66'h0);
    check("reset_o13", {52'h0, o13}, 66'h0);
    @(negedge clk_i);
    reset_n_i = 1'b1;

    // Idle after reset: nothing captured until v_i rises.
    @(negedge clk_i);
    a_i = 65'h55; b_i = 65'h66;
    repeat (2) @(posedge clk_i);
    #1;
    check("idle_after_reset_o", o, 66'h0);

    foreach (vecs[i]) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].c);
      check($sformatf("vec%0d_o", i), o, vecs[i].exp);
      check($sformatf("vec%0d_v_o", i), {65'h0, v_o}, 66'h1);
    end

    // Hold: o keeps its value while v_i is low and operands wander.
    apply(65'd5, 65'd6, 1'b0);
    check("hold_capture", o, 66'd11);
    @(negedge clk_i);
    v_i = 1'b0;
    a_i = 65'h1_FFFF_FFFF_FFFF_FFFF; b_i = 65'h0_DEAD_BEEF_CAFE_F00D; c_i = 1'b1;
    repeat (lat_lp) @(posedge clk_i);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      a_i = {$urandom, $urandom, 1'b1}; b_i = {$urandom, $urandom, 1'b0};
      @(posedge clk_i);
      #1;
      check($sformatf("hold_o_%0d", k), o, 66'd11);
      check($sformatf("hold_v_o_%0d", k), {65'h0, v_o}, 66'h0);
    end

    // Async reset mid-cycle clears without a clock edge.
    @(posedge clk_i);
    #2;
    reset_n_i = 1'b0;
    #1;
    check("async_reset_o", o, 66'h0);
    check("async_reset_v_o", {65'h0, v_o}, 66'h0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    apply(65'd3, 65'd4, 1'b0);
    check("post_reset_o", o, 66'd7);
    check("post_reset_v_o", {65'h0, v_o}, 66'h1);
    @(negedge clk_i);
    v_i = 1'b0;

    // 13-bit, 4-bit blocks: corners then random, one new operand set every cycle.
    sweep_fail = 0;
    for (int i = 0; i < sweep_lp + lat_lp; i++) begin
      @(negedge clk_i);
      if (i >= lat_lp) begin
        want = q_exp.pop_front();
        checks++;
        if (o13 !== want || vo13 !== 1'b1) begin
          failures++;
          sweep_fail++;
          if (sweep_fail <= 8)
            $display("FAIL sweep13 item %0d: got 0x%0h v=%0b expected 0x%0h v=1",
                     i - lat_lp, o13, vo13, want);
        end
      end
      if (i < sweep_lp) begin
        case (i)
          0: begin a13 = 13'h1FFF; b13 = 13'h1FFF; c13 = 1'b1; end
          1: begin a13 = 13'h0;    b13 = 13'h0;    c13 = 1'b0; end
          2: begin a13 = 13'h1FFF; b13 = 13'h0;    c13 = 1'b1; end
          3: begin a13 = 13'h0FFF; b13 = 13'h0;    c13 = 1'b1; end
          4: begin a13 = 13'h000F; b13 = 13'h0001; c13 = 1'b0; end
          default: begin
            a13 = 13'($urandom); b13 = 13'($urandom); c13 = 1'($urandom);
          end
        endcase
        v13 = 1'b1;
        exp13 = {1'b0, a13} + {1'b0, b13} + {13'h0, c13};
        q_exp.push_back(exp13);
      end else begin
        v13 = 1'b0;
      end
    end
    check("sweep13_corner_last", {52'h0, o13}, 66'h0 + 66'({1'b0, a13} + {1'b0, b13} + {13'h0, c13}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
